// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct encodings, fetch FSM states and the default reset PC.
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned OPW  = 6;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

  // Primary opcodes
  localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPW-1:0] LW       = 6'h23;
  localparam logic [OPW-1:0] SW       = 6'h2B;
  localparam logic [OPW-1:0] J        = 6'h02;
  localparam logic [OPW-1:0] JAL      = 6'h03;
  localparam logic [OPW-1:0] BNE      = 6'h05;
  localparam logic [OPW-1:0] XORI     = 6'h0E;

  // R-type funct codes
  localparam logic [OPW-1:0] ADD      = 6'h20;
  localparam logic [OPW-1:0] SUB      = 6'h22;
  localparam logic [OPW-1:0] SLT      = 6'h2A;
  localparam logic [OPW-1:0] JR       = 6'h08;
  localparam logic [OPW-1:0] SYSCALL  = 6'h0C;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic jump;
    logic branch;
    logic jump_sel;
  } ctrl_t;

  function automatic logic is_syscall(input logic [XLEN-1:0] word);
    return (word[31:26] == OP_RTYPE) && (word[5:0] == SYSCALL);
  endfunction

  function automatic logic is_known_op(input logic [OPW-1:0] op);
    return (op == OP_RTYPE) || (op == LW) || (op == SW) || (op == J) ||
           (op == JAL) || (op == BNE) || (op == XORI);
  endfunction

  function automatic logic is_known_funct(input logic [OPW-1:0] fn);
    return (fn == ADD) || (fn == SUB) || (fn == SLT) || (fn == JR) || (fn == SYSCALL);
  endfunction

endpackage

// File: rtl/next_pc.sv
// Combinational next-PC selection: JR > J/JAL > taken BNE > sequential, with JR misalignment flag.
module next_pc
  import mips_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] instr,
  input  ctrl_t           ctrl,
  input  logic            zero,
  input  logic [XLEN-1:0] jr_addr,
  output logic [XLEN-1:0] npc_c,
  output logic            misalign_c
);

  logic [XLEN-1:0] pc4;
  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] jmp_tgt;
  logic            unused_ok;

  assign pc4     = pc + XLEN'(4);
  assign br_off  = {{14{instr[15]}}, instr[15:0], 2'b00};
  assign jmp_tgt = {pc4[31:28], instr[25:0], 2'b00};

  // Opcode bits are decoded upstream; only the immediate/target fields matter here.
  assign unused_ok = ^instr[31:26];

  always_comb begin
    npc_c      = pc4;
    misalign_c = 1'b0;
    if (ctrl.jump && ctrl.jump_sel) begin
      npc_c      = {jr_addr[31:2], 2'b00};
      misalign_c = |jr_addr[1:0];
    end else if (ctrl.jump) begin
      npc_c = jmp_tgt;
    end else if (ctrl.branch && !zero) begin
      npc_c = pc4 + br_off;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch / PC sequencer for the multicycle MIPS core (FETCH, DECODE, EXECUTE, HALT).
// Define FETCH_COUNT_EN to build the retired-instruction counter; otherwise instr_count is 0.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic [OPW-1:0]  opcode,
  output logic [OPW-1:0]  funct,
  output logic            instr_valid,
  input  logic            Jump,
  input  logic            Branch,
  input  logic            JumpSel,
  input  logic            zero,
  input  logic [XLEN-1:0] jr_addr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] link_addr,
  output logic            halted,
  output logic            align_err,
  output logic [XLEN-1:0] instr_count
);

  fetch_state_e    state;
  fetch_state_e    state_nx;
  logic            accept_c;
  ctrl_t           ctrl_c;
  logic [XLEN-1:0] npc_c;
  logic            misalign_c;

  // imem_req is only ever high in FETCH, so it alone qualifies an incoming word.
  assign accept_c  = imem_req && imem_valid;
  assign ctrl_c    = '{jump: Jump, branch: Branch, jump_sel: JumpSel};
  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];

  next_pc u_next_pc (
    .pc         (pc),
    .instr      (instr),
    .ctrl       (ctrl_c),
    .zero       (zero),
    .jr_addr    (jr_addr),
    .npc_c      (npc_c),
    .misalign_c (misalign_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_FETCH;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_FETCH:   if (accept_c) state_nx = ST_DECODE;
      ST_DECODE:  state_nx = is_syscall(instr) ? ST_HALT : ST_EXECUTE;
      ST_EXECUTE: state_nx = ST_FETCH;
      ST_HALT:    state_nx = ST_HALT;
      default:    state_nx = ST_FETCH;
    endcase
  end

  // Status outputs are registered copies of the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      imem_req    <= (state_nx == ST_FETCH);
      instr_valid <= (state_nx == ST_DECODE) || (state_nx == ST_EXECUTE);
      halted      <= (state_nx == ST_HALT);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      link_addr <= RESET_PC + XLEN'(4);
      instr     <= '0;
      align_err <= 1'b0;
    end else begin
      if ((state == ST_FETCH) && accept_c) instr <= imem_rdata;
      if (state == ST_EXECUTE) begin
        pc        <= npc_c;
        link_addr <= npc_c + XLEN'(4);
        align_err <= align_err | misalign_c;
      end
    end
  end

`ifdef FETCH_COUNT_EN
  logic [XLEN-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset)                    count_q <= '0;
    else if (state == ST_EXECUTE) count_q <= count_q + XLEN'(1);
  end

  assign instr_count = count_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed test-plan cases pinned with literals, then random traffic.
module tb_fetch_unit;

  localparam int P_IDLE  = 0;
  localparam int P_FETCH = 1;
  localparam int P_DEC   = 2;
  localparam int P_EXEC  = 3;
  localparam int P_HALT  = 4;

`ifdef FETCH_COUNT_EN
  localparam logic [31:0] CNT_INC = 32'd1;
`else
  localparam logic [31:0] CNT_INC = 32'd0;
`endif

  localparam logic [31:0] W_ADD  = 32'h0022_1820;
  localparam logic [31:0] W_SYS  = 32'h0000_000C;
  localparam logic [31:0] W_JR   = 32'h03E0_0008;
  localparam logic [31:0] W_JAL  = 32'h0C00_0040;
  localparam logic [31:0] W_J3   = 32'h0800_0003;
  localparam logic [31:0] W_BNEM1 = 32'h1420_FFFF;
  localparam logic [31:0] W_BNEM4 = 32'h1420_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        instr_valid;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        JumpSel = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] jr_addr = '0;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        halted;
  logic        align_err;
  logic [31:0] instr_count;

  fetch_unit dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr(instr),
    .opcode(opcode), .funct(funct), .instr_valid(instr_valid),
    .Jump(Jump), .Branch(Branch), .JumpSel(JumpSel), .zero(zero),
    .jr_addr(jr_addr), .pc(pc), .link_addr(link_addr), .halted(halted),
    .align_err(align_err), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Reference model: instruction-level view of where the sequencer must be.
  int          m_phase = P_IDLE;
  logic [31:0] m_pc = '0;
  logic [31:0] m_instr = '0;
  logic [31:0] m_cnt = '0;
  logic        m_align = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  task automatic model_step();
    logic [31:0] pc4;
    if (reset) begin
      m_pc = 32'h0; m_instr = '0; m_cnt = '0; m_align = 1'b0; m_phase = P_IDLE;
    end else begin
      case (m_phase)
        P_IDLE:  m_phase = P_FETCH;
        P_FETCH: if (imem_valid) begin m_instr = imem_rdata; m_phase = P_DEC; end
        P_DEC:   m_phase = (m_instr[31:26] == 6'd0 && m_instr[5:0] == 6'd12) ? P_HALT : P_EXEC;
        P_EXEC: begin
          pc4 = m_pc + 32'd4;
          if (Jump && JumpSel) begin
            m_pc = jr_addr - 32'(jr_addr % 4);
            if (jr_addr % 4 != 0) m_align = 1'b1;
          end else if (Jump)
            m_pc = (pc4 & 32'hF000_0000) + (32'(m_instr[25:0]) * 32'd4);
          else if (Branch && !zero)
            m_pc = pc4 + 32'($signed(m_instr[15:0])) * 32'd4;
          else
            m_pc = pc4;
          m_cnt = m_cnt + CNT_INC;
          m_phase = P_FETCH;
        end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("imem_req",    32'(imem_req),    32'(m_phase == P_FETCH));
      chk("imem_addr",   imem_addr,        m_pc);
      chk("pc",          pc,               m_pc);
      chk("link_addr",   link_addr,        m_pc + 32'd4);
      chk("instr",       instr,            m_instr);
      chk("opcode",      32'(opcode),      32'(m_instr >> 26));
      chk("funct",       32'(funct),       m_instr % 64);
      chk("instr_valid", 32'(instr_valid), 32'(m_phase == P_DEC || m_phase == P_EXEC));
      chk("halted",      32'(halted),      32'(m_phase == P_HALT));
      chk("align_err",   32'(align_err),   32'(m_align));
      chk("instr_count", instr_count,      m_cnt);
    end
  end

  task automatic do_reset();
    reset = 1'b1; imem_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // One instruction through a memory with `waits` stall cycles; returns in FETCH or HALT.
  task automatic run_instr(input logic [31:0] word, input int waits,
                           input bit j, input bit b, input bit js, input bit z,
                           input logic [31:0] jr);
    Jump = j; Branch = b; JumpSel = js; zero = z; jr_addr = jr;
    imem_valid = 1'b0;
    for (int k = 0; k < 8 && imem_req !== 1'b1; k++) tick();
    chk("fetch_wait", 32'(imem_req), 32'd1);
    repeat (waits) tick();
    imem_valid = 1'b1; imem_rdata = word;
    tick();
    imem_valid = 1'b0;
    tick();
    if (m_phase == P_EXEC) tick();
  endtask

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    int sel;
    w = $urandom;
    sel = $urandom_range(0, 39);
    if (sel == 0) w = {6'd0, w[25:6], 6'h0C};
    else if (sel < 10) w[31:26] = 6'h05;
    else if (sel < 14) w[31:26] = 6'h03;
    return w;
  endfunction

  initial begin
    do_reset();
    chk_on = 1'b1;
    chk("rst_pc", pc, 32'h0);
    chk("rst_link", link_addr, 32'h4);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_cnt", instr_count, 32'd0);

    // ADD at 0, zero-wait
    run_instr(W_ADD, 0, 0, 0, 0, 0, 32'h0);
    chk("add_pc", imem_addr, 32'h4);
    chk("add_cnt", instr_count, CNT_INC);
    for (int i = 0; i < 3; i++) run_instr(W_ADD, 0, 0, 0, 0, 0, 32'h0);
    chk("seq_pc", pc, 32'h10);

    // BNE imm=-1 at 0x10
    run_instr(W_BNEM1, 0, 0, 1, 0, 0, 32'h0);
    chk("bne_taken", pc, 32'h10);
    run_instr(W_BNEM1, 0, 0, 1, 0, 1, 32'h0);
    chk("bne_not_taken", pc, 32'h14);
    for (int i = 0; i < 3; i++) run_instr(W_ADD, 0, 0, 0, 0, 0, 32'h0);
    chk("jal_link", link_addr, 32'h24);
    run_instr(W_JAL, 0, 1, 0, 0, 0, 32'h0);
    chk("jal_pc", pc, 32'h100);
    run_instr(W_JR, 0, 1, 0, 1, 0, 32'h206);
    chk("jr_pc", pc, 32'h204);
    chk("jr_align", 32'(align_err), 32'd1);

    // Memory stalls two cycles at 0x204
    Jump = 0; Branch = 0; JumpSel = 0; imem_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, 32'h204);
    end
    imem_valid = 1'b1; imem_rdata = W_ADD;
    tick();
    imem_valid = 1'b0;
    chk("stall_decode", 32'(instr_valid), 32'd1);
    tick(); tick();
    chk("stall_pc", pc, 32'h208);

    // SYSCALL halts
    run_instr(W_SYS, 0, 0, 0, 0, 0, 32'h0);
    chk("sys_halted", 32'(halted), 32'd1);
    for (int k = 0; k < 4; k++) begin
      imem_valid = 1'b1; imem_rdata = W_ADD;
      tick();
      chk("halt_req", 32'(imem_req), 32'd0);
      chk("halt_pc", pc, 32'h208);
      chk("halt_cnt", instr_count, 32'd12 * CNT_INC);
    end
    do_reset();
    chk("halt_reset_pc", pc, 32'h0);
    chk("halt_reset_halted", 32'(halted), 32'd0);

    // Backward branch below zero and wrap at the top of the address space
    run_instr(W_BNEM4, 0, 0, 1, 0, 0, 32'h0);
    chk("wrap_down", pc, 32'hFFFF_FFF4);
    for (int i = 0; i < 3; i++) run_instr(W_ADD, 0, 0, 0, 0, 0, 32'h0);
    chk("wrap_up", pc, 32'h0);

    // Jump and Branch together: Jump wins
    run_instr(W_J3, 0, 1, 1, 0, 0, 32'h0);
    chk("jump_wins", pc, 32'hC);
    for (int i = 0; i < 13; i++) run_instr(W_ADD, 0, 0, 0, 0, 0, 32'h0);
    chk("pre_mid_reset_pc", pc, 32'h40);

    // Reset while fetching at 0x40
    imem_valid = 1'b0;
    tick();
    reset = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("mid_reset_pc", pc, 32'h0);
    chk("mid_reset_instr", instr, 32'h0);
    reset = 1'b0;
    run_instr(W_ADD, 1, 0, 0, 0, 0, 32'h0);
    chk("post_reset_instr", instr, W_ADD);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      logic [31:0] r;
      reset = ($urandom_range(0, 149) == 0) ||
              (m_phase == P_HALT && $urandom_range(0, 3) == 0);
      imem_valid = reset ? 1'b0 : ($urandom_range(0, 2) != 0);
      imem_rdata = gen_word();
      Jump = 1'($urandom); Branch = 1'($urandom);
      JumpSel = 1'($urandom); zero = 1'($urandom);
      r = $urandom;
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      if ($urandom_range(0, 49) == 0) r = 32'hFFFF_FFFC;
      jr_addr = r;
      tick();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch and program-counter sequencer for the multicycle MIPS core. It owns the PC, reads instruction words over a request/valid handshake, and presents `opcode`/`funct` to the control decoder. One cycle later it samples the decoder's `Jump`/`Branch`/`JumpSel` outputs and computes the next PC. It also stops the core on SYSCALL.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC loaded on reset; must be word-aligned.
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address; equals `pc`, stable while `imem_req` is high
- `imem_valid`  in  1  `imem_rdata` is valid; sampled only while `imem_req` is high
- `imem_rdata`  in  32  instruction word
- `instr`  out  32  current instruction register
- `opcode`  out  6  `instr[31:26]`, to control
- `funct`  out  6  `instr[5:0]`, to control
- `instr_valid`  out  1  high in DECODE and EXECUTE
- `Jump`, `Branch`, `JumpSel`  in  1 each  decoder outputs, sampled in EXECUTE
- `zero`  in  1  ALU zero flag (BNE compare)
- `jr_addr`  in  32  rs register value for JR
- `pc`  out  32  address of the current instruction
- `link_addr`  out  32  `pc+4`, the JAL return address
- `halted`  out  1  high once SYSCALL is reached
- `align_err`  out  1  sticky; set by a misaligned JR target
- `instr_count`  out  32  retired-instruction count (see Configuration)

## Operation
- States: FETCH, DECODE, EXECUTE, HALT.
- **FETCH**
  - `imem_req`=1.
  - On `imem_valid`: latch `imem_rdata` into `instr`, then go to DECODE. Otherwise stay in FETCH.
  - The first cycle after reset is FETCH.
- **DECODE**
  - `instr` is held stable for one cycle while the decoder registers its outputs.
  - If opcode=0 and funct=6'b001100 (SYSCALL), go to HALT. Otherwise go to EXECUTE.
- **EXECUTE**
  - Sample the control inputs, load the next PC, increment `instr_count`, then go to FETCH.
  - Next-PC priority:
    - `Jump`&`JumpSel`: `{jr_addr[31:2],2'b00}`. If `jr_addr[1:0]`≠0, set `align_err`.
    - `Jump`&!`JumpSel`: `{pc4[31:28], instr[25:0], 2'b00}`.
    - `Branch`&!`zero`: `pc4 + {{14{instr[15]}}, instr[15:0], 2'b00}`.
    - Otherwise: `pc4`.
  - `pc4` = `pc + 32'd4`. No delay slot.
- **HALT**: terminal. `halted`=1, `imem_req`=0, and `pc`/`instr` are frozen. Only `reset` leaves HALT.
- Arithmetic: all PC arithmetic is 32-bit modulo. `32'hFFFF_FFFC + 4` wraps to 0, and a backward branch below 0 wraps.
- `link_addr` = `pc + 4`, valid whenever `instr_valid` is high.
- An unknown opcode is treated as whatever the decoder outputs. With all control inputs at 0, the result is sequential flow.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `link_addr`=`RESET_PC+4`
  - `instr`=0 (NOOP)
  - `imem_req`=0, `instr_valid`=0, `halted`=0, `align_err`=0, `instr_count`=0
  - state=FETCH
- `imem_req` is asserted in the first cycle after reset deasserts.
- Zero-wait memory (`imem_valid` in the same cycle as `imem_req`): 3 cycles per instruction (FETCH, DECODE, EXECUTE). Each memory wait cycle adds one cycle.
- The new `pc` is visible on `imem_addr` in the cycle after EXECUTE.
- `reset` overrides every state, including mid-FETCH. The memory shares `reset` and must drop `imem_valid` while `reset` is high. Any word that arrives while `reset` is high is discarded.
- `imem_valid` while `imem_req`=0 is ignored.
- `Jump` and `Branch` both high: `Jump` wins.

## Configuration
- `FETCH_COUNT_EN` defined: `instr_count` increments once per EXECUTE, wraps at 2^32, and holds in HALT.
- `FETCH_COUNT_EN` undefined: the counter register is not built and `instr_count` is tied to 0. The port list is the same in both builds.

## Structure
- Shared package `mips_pkg`:
  - opcode/funct constants: `LW`, `SW`, `J`, `JAL`, `BNE`, `XORI`, `ADD`, `SUB`, `SLT`, `JR`, `SYSCALL`
  - fetch state enum
  - `RESET_PC` default
- Sub-module `next_pc`: combinational; inputs `pc`, `instr`, control bits, `zero`, `jr_addr`; outputs next PC and the misalign flag.
- The state machine and registers live in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0 and zero-wait memory; ADD at address 0 → `imem_addr`=0, then 4 after 3 cycles; `instr_count`=1.
- Memory holds `imem_valid` low for 2 cycles → `imem_addr` stays stable and `imem_req` stays high; DECODE starts the cycle after `imem_valid` rises.
- BNE with imm=16'hFFFF at pc=0x10, `zero`=0 → next pc=0x10. Same instruction with `zero`=1 → next pc=0x14.
- JAL target 26'h0000040 at pc=0x20 → `link_addr`=0x24, next pc=0x100. JR with `jr_addr`=0x206 → next pc=0x204 and `align_err`=1.
- SYSCALL → `halted`=1 from the cycle after DECODE, `imem_req` stays 0 and `instr_count` frozen; `reset` → back to FETCH at `RESET_PC`.
- `reset` asserted mid-FETCH with `pc`=0x40 → `pc`=`RESET_PC` next cycle and the in-flight word is discarded.
